// File: rtl/elevator_request_latch.sv
// Button-press capture for the elevator controller: latches hall/car calls and clears them when served.
// Optional per-bit input debounce filter enabled by defining DEBOUNCE_EN.
module elevator_request_latch #(
   parameter int NUM_FLOORS = 4,
   parameter int DB_CYCLES  = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_FLOORS-2:0] raw_up,
   input  logic [NUM_FLOORS-2:0] raw_down,
   input  logic [NUM_FLOORS-1:0] raw_in,
   input  logic [2:0]            position,
   input  logic                  open,
   input  logic [1:0]            direction,
   output logic [NUM_FLOORS-2:0] req_up,
   output logic [NUM_FLOORS-2:0] req_down,
   output logic [NUM_FLOORS-1:0] req_in,
   output logic                  req_any,
   output logic                  req_above,
   output logic                  req_below
);

   localparam int NH = NUM_FLOORS - 1;
   localparam int NB = 2 * NH + NUM_FLOORS;

   logic [NB-1:0]         raw_all;
   logic [NB-1:0]         flt_all;
   logic [NB-1:0]         flt_q;
   logic [NB-1:0]         press_all;
   logic                  armed;
   logic                  serve;
   logic [2:0]            srv_floor;
   logic [NH-1:0]         clr_up;
   logic [NH-1:0]         clr_dn;
   logic [NUM_FLOORS-1:0] clr_in;
   logic [NUM_FLOORS-1:0] pend;

   assign raw_all = {raw_in, raw_down, raw_up};

`ifdef DEBOUNCE_EN
   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES);
   localparam logic [CW-1:0] DB_ARM = CW'(DB_CYCLES - 1);

   logic [CW-1:0] db_cnt [NB];

   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (!reset_n || !raw_all[i])
            db_cnt[i] <= '0;
         else if (db_cnt[i] != DB_MAX)
            db_cnt[i] <= db_cnt[i] + CW'(1);
      end
   end

   // Current sample counts toward the run, so the bit is accepted on the DB_CYCLES-th high sample.
   always_comb begin
      flt_all = '0;
      for (int i = 0; i < NB; i++)
         flt_all[i] = raw_all[i] && (db_cnt[i] >= DB_ARM);
   end
`else
   assign flt_all = raw_all;
`endif

   // armed stays low for the first edge out of reset so a held button only loads history.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         flt_q <= '0;
         armed <= 1'b0;
      end else begin
         flt_q <= flt_all;
         armed <= 1'b1;
      end
   end

   assign press_all = flt_all & ~flt_q & {NB{armed}};
   assign serve     = open & ~position[0];
   assign srv_floor = position >> 1;

   always_comb begin
      clr_up = '0;
      clr_dn = '0;
      clr_in = '0;
      if (serve) begin
         for (int f = 0; f < NUM_FLOORS; f++)
            if (int'(srv_floor) == f) clr_in[f] = 1'b1;
         for (int f = 0; f < NH; f++) begin
            if (int'(srv_floor) == f && direction != 2'b10)     clr_up[f] = 1'b1;
            if (int'(srv_floor) == f + 1 && direction != 2'b01) clr_dn[f] = 1'b1;
         end
      end
   end

   // Clear is applied after set so a press at the floor being served is dropped.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         req_up   <= '0;
         req_down <= '0;
         req_in   <= '0;
      end else begin
         req_up   <= (req_up   | press_all[NH-1:0])      & ~clr_up;
         req_down <= (req_down | press_all[2*NH-1:NH])   & ~clr_dn;
         req_in   <= (req_in   | press_all[NB-1:2*NH])   & ~clr_in;
      end
   end

   assign pend    = req_in | {1'b0, req_up} | {req_down, 1'b0};
   assign req_any = |pend;

   always_comb begin
      req_above = 1'b0;
      req_below = 1'b0;
      for (int f = 0; f < NUM_FLOORS; f++) begin
         if (pend[f] && (2 * f > int'(position))) req_above = 1'b1;
         if (pend[f] && (2 * f < int'(position))) req_below = 1'b1;
      end
   end

endmodule

// File: tb/tb_elevator_request_latch.sv
// Randomized and directed bench for elevator_request_latch against a floor-level request model.
module tb_elevator_request_latch;

   localparam int NF = 4;
   localparam int DB = 3;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [NF-2:0] raw_up, raw_down, req_up, req_down;
   logic [NF-1:0] raw_in, req_in;
   logic [2:0]    position;
   logic          open;
   logic [1:0]    direction;
   logic          req_any, req_above, req_below;

   int n_cmp = 0;
   int n_err = 0;

   // Model state: one pending flag per call type and floor.
   bit hall_up [NF];
   bit hall_dn [NF];
   bit car     [NF];
   bit prev_up [NF];
   bit prev_dn [NF];
   bit prev_in [NF];
   int run_up  [NF];
   int run_dn  [NF];
   int run_in  [NF];
   bit fresh;

   elevator_request_latch #(.NUM_FLOORS(NF), .DB_CYCLES(DB)) dut (
      .clk(clk), .reset_n(reset_n),
      .raw_up(raw_up), .raw_down(raw_down), .raw_in(raw_in),
      .position(position), .open(open), .direction(direction),
      .req_up(req_up), .req_down(req_down), .req_in(req_in),
      .req_any(req_any), .req_above(req_above), .req_below(req_below)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit filt(input bit raw, inout int run);
`ifdef DEBOUNCE_EN
      run = raw ? run + 1 : 0;
      return run >= DB;
`else
      return raw;
`endif
   endfunction

   task automatic model_edge();
      bit fu, fd, fi;
      int s;
      if (!reset_n) begin
         for (int f = 0; f < NF; f++) begin
            hall_up[f] = 0; hall_dn[f] = 0; car[f] = 0;
            prev_up[f] = 0; prev_dn[f] = 0; prev_in[f] = 0;
            run_up[f] = 0; run_dn[f] = 0; run_in[f] = 0;
         end
         fresh = 1;
         return;
      end
      // Floor f: up button exists below top floor, down button above floor 0.
      for (int f = 0; f < NF; f++) begin
         fu = (f < NF - 1) ? filt(raw_up[f], run_up[f]) : 0;
         fd = (f > 0) ? filt(raw_down[f-1], run_dn[f]) : 0;
         fi = filt(raw_in[f], run_in[f]);
         if (!fresh) begin
            if (fu && !prev_up[f]) hall_up[f] = 1;
            if (fd && !prev_dn[f]) hall_dn[f] = 1;
            if (fi && !prev_in[f]) car[f] = 1;
         end
         prev_up[f] = fu; prev_dn[f] = fd; prev_in[f] = fi;
      end
      fresh = 0;
      if (open && (position % 2 == 0)) begin
         s = position / 2;
         if (s < NF) begin
            car[s] = 0;
            if (direction != 2'b10) hall_up[s] = 0;
            if (direction != 2'b01) hall_dn[s] = 0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      logic [NF-2:0] eu, ed;
      logic [NF-1:0] ei;
      bit any, above, below;
      any = 0; above = 0; below = 0;
      for (int f = 0; f < NF; f++) begin
         ei[f] = car[f];
         if (f < NF - 1) eu[f] = hall_up[f];
         if (f > 0) ed[f-1] = hall_dn[f];
         if (car[f] || hall_up[f] || hall_dn[f]) begin
            any = 1;
            if (2 * f > int'(position)) above = 1;
            if (2 * f < int'(position)) below = 1;
         end
      end
      check_eq({tag, ".req_up"}, 32'(req_up), 32'(eu));
      check_eq({tag, ".req_down"}, 32'(req_down), 32'(ed));
      check_eq({tag, ".req_in"}, 32'(req_in), 32'(ei));
      check_eq({tag, ".req_any"}, 32'(req_any), 32'(any));
      check_eq({tag, ".req_above"}, 32'(req_above), 32'(above));
      check_eq({tag, ".req_below"}, 32'(req_below), 32'(below));
   endtask

   task automatic step(input string tag, input logic [2:0] up, input logic [2:0] dn,
                       input logic [3:0] in, input logic [2:0] pos, input logic op,
                       input logic [1:0] dir, input logic rn);
      raw_up = up; raw_down = dn; raw_in = in;
      position = pos; open = op; direction = dir; reset_n = rn;
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   initial begin
      raw_up = '0; raw_down = '0; raw_in = '0;
      position = '0; open = 0; direction = '0; reset_n = 0;

      step("rst", 0, 0, 0, 0, 0, 0, 0);
      step("rst", 0, 0, 0, 0, 0, 0, 0);
      check_eq("rst_any", 32'(req_any), 32'd0);
      step("idle", 0, 0, 0, 0, 0, 0, 1);

      // Single-cycle car call for floor 2 while parked at floor 0.
      step("t1", 0, 0, 4'b0100, 0, 0, 0, 1);
`ifndef DEBOUNCE_EN
      check_eq("t1_req_in", 32'(req_in), 32'h4);
      check_eq("t1_above", 32'(req_above), 32'd1);
      check_eq("t1_below", 32'(req_below), 32'd0);
`endif
      step("t1", 0, 0, 0, 0, 0, 0, 1);
      step("t1", 0, 0, 0, 4, 1, 0, 1);

      // Held hall-up at floor 1 latches once, is served, and stays clear while held.
      for (int i = 0; i < 5; i++) step("t2_hold", 3'b010, 0, 0, 6, 0, 0, 1);
      check_eq("t2_latched", 32'(req_up), 32'h2);
      step("t2_serve", 3'b010, 0, 0, 2, 1, 2'b01, 1);
      check_eq("t2_served", 32'(req_up), 32'h0);
      for (int i = 0; i < 3; i++) step("t2_keep", 3'b010, 0, 0, 2, 0, 0, 1);
      check_eq("t2_stays", 32'(req_up), 32'h0);
      step("t2", 0, 0, 0, 0, 0, 0, 1);

      // Down call at floor 2 survives an upward stop and clears on a downward stop.
      for (int i = 0; i < 3; i++) step("t3_press", 0, 3'b010, 0, 0, 0, 0, 1);
      step("t3", 0, 0, 0, 0, 0, 0, 1);
      step("t3_up", 0, 0, 0, 4, 1, 2'b01, 1);
      check_eq("t3_kept", 32'(req_down), 32'h2);
      step("t3_dn", 0, 0, 0, 4, 1, 2'b10, 1);
      check_eq("t3_cleared", 32'(req_down), 32'h0);

      // Press at the floor being served is dropped; another floor latches on the same edge.
      step("t4_same", 0, 0, 4'b1000, 6, 1, 0, 1);
      check_eq("t4_clear_wins", 32'(req_in[3]), 32'd0);
      step("t4", 0, 0, 0, 6, 0, 0, 1);
      step("t4_other", 0, 0, 4'b1001, 6, 1, 0, 1);
`ifndef DEBOUNCE_EN
      check_eq("t4_other_set", 32'(req_in), 32'h1);
`endif
      step("t4", 0, 0, 0, 5, 0, 0, 1);

      // Pending requests dropped by reset; a button held across reset does not latch.
      for (int i = 0; i < 3; i++) step("t5_set", 3'b001, 0, 4'b1001, 3, 0, 0, 1);
      step("t5", 0, 0, 4'b0100, 3, 0, 0, 1);
      step("t5_rst", 0, 0, 4'b0100, 3, 0, 0, 0);
      check_eq("t5_rst_any", 32'(req_any), 32'd0);
      for (int i = 0; i < 5; i++) step("t5_held", 0, 0, 4'b0100, 3, 0, 0, 1);
`ifndef DEBOUNCE_EN
      check_eq("t5_no_latch", 32'(req_in), 32'h0);
`endif
      step("t5", 0, 0, 0, 3, 0, 0, 1);

      // Glitch pattern on car button 2 followed by a clean hold.
      step("t6", 0, 0, 4'b0100, 0, 0, 0, 1);
      step("t6", 0, 0, 4'b0100, 0, 0, 0, 1);
      step("t6", 0, 0, 4'b0000, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) step("t6", 0, 0, 4'b0100, 0, 0, 0, 1);
      step("t6", 0, 0, 0, 0, 0, 0, 1);

      // Random traffic, sparse button activity with holds, occasional reset.
      for (int i = 0; i < 600; i++) begin
         logic [2:0] u, d;
         logic [3:0] c;
         for (int b = 0; b < 3; b++) begin
            u[b] = ($urandom % 4) == 0 ? ~raw_up[b] : raw_up[b];
            d[b] = ($urandom % 4) == 0 ? ~raw_down[b] : raw_down[b];
         end
         for (int b = 0; b < 4; b++)
            c[b] = ($urandom % 4) == 0 ? ~raw_in[b] : raw_in[b];
         step("rnd", u, d, c, 3'($urandom_range(0, 7)), 1'($urandom % 3 == 0),
              2'($urandom), ($urandom % 60) != 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/elevator_request_latch.md
Name: elevator_request_latch

Overview:
Upstream stage of the elevator controller. It captures raw hall-call and car-call button presses, holds them as pending requests, and clears each request when the car serves it (door open at that floor with a compatible direction). It drives the controller's button_up/button_down/button_in inputs with pending requests and provides summary flags.

Parameters:
NUM_FLOORS, 4, number of floors; floor f is stopped at when position == 2*f
DB_CYCLES, 3, consecutive high samples needed before a press is accepted; used only with DEBOUNCE_EN

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  synchronous active-low reset
raw_up  input  NUM_FLOORS-1  hall up buttons, bit f = floor f (floors 0..NUM_FLOORS-2)
raw_down  input  NUM_FLOORS-1  hall down buttons, bit f = floor f+1
raw_in  input  NUM_FLOORS  car buttons, bit f = floor f
position  input  3  car position from controller; even = at floor position/2, odd = between floors
open  input  1  door open from controller
direction  input  2  controller direction: 00 idle, 01 up, 10 down, 11 reserved (treated as idle)
req_up  output  NUM_FLOORS-1  pending up calls, registered; feeds controller button_up
req_down  output  NUM_FLOORS-1  pending down calls, registered; feeds controller button_down
req_in  output  NUM_FLOORS  pending car calls, registered; feeds controller button_in
req_any  output  1  OR of all pending bits
req_above  output  1  any pending request for a floor f with 2*f > position
req_below  output  1  any pending request for a floor f with 2*f < position

Behaviour:
- Reset (reset_n low at a rising clk edge): req_up, req_down, req_in cleared to 0. Edge-detect history registers cleared to 0. Debounce counters cleared, if present. req_any/req_above/req_below therefore 0.
- Press detection: per bit, press = raw & ~raw_q, where raw_q is the raw value registered on the previous edge. A held button creates one press only. After a request is cleared, it is not re-latched until the button is released and pressed again.
- Set latency: a press sampled at edge n makes the req bit 1 after edge n, so it is visible in cycle n+1.
- Set is sticky: a req bit stays 1 until a clear condition occurs or reset.
- Serve condition: open==1 and position even. Floor s = position>>1.
  - Clear req_in[s] always.
  - Clear req_up[s] when direction is 00, 01, or 11, provided s <= NUM_FLOORS-2.
  - Clear req_down[s-1] when direction is 00, 10, or 11, provided s >= 1.
- Simultaneous set and clear on the same bit in the same edge: clear wins, because the request is served immediately.
- Set and clear on different bits in the same edge: both take effect.
- open==1 with odd position is an illegal controller state. No clears occur in that case; sets still occur.
- Summary flags: combinational from the registered req bits and the position input. Floor index is compared as 2*f against position. A request at the current floor counts as neither above nor below.
- Reset asserted mid-operation drops all pending requests. A button still held through reset deassertion does not latch, because raw_q is loaded with the held value on the first edge out of reset.

Optional Feature:
DEBOUNCE_EN.
- Defined: each raw bit passes through a filter. A per-bit counter counts consecutive high samples and saturates at DB_CYCLES. The filtered bit becomes 1 when the count reaches DB_CYCLES and returns to 0 (counter reset) on any low sample. Press detection uses the filtered bit. Set latency becomes DB_CYCLES cycles after the first high sample.
- Undefined: no filter, no counters, and the raw bits feed press detection directly with 1-cycle latency.

Test Plan:
1. Reset, then raw_in=4'b0100 for 1 cycle with position=0, open=0 -> req_in=4'b0100 next cycle, req_any=1, req_above=1, req_below=0.
2. Hold raw_up=3'b010 for 5 cycles, car moves away from floor 1 -> req_up=3'b010 latched once. Serve at position=2, open=1, direction=01 -> req_up=3'b000 next cycle. Keep holding -> stays 000.
3. Pending req_down=3'b010 (floor 2), car at position=4, open=1, direction=01 -> req_down stays 010. Same with direction=10 -> cleared to 000.
4. position=6, open=1, raw_in=4'b1000 rising on the same edge -> req_in[3] stays 0 (clear wins). raw_in[0] rising on the same edge -> req_in=4'b0001.
5. req_in=4'b1001, req_up=3'b001 pending, reset_n=0 for 1 edge -> all req outputs 0. Button held through reset does not latch.
6. (DEBOUNCE_EN, DB_CYCLES=3) raw_in[2] pattern 1,1,0,1,1,1 -> req_in[2] rises only after the third consecutive 1. A glitch of 1,1,0 never latches.
